// File: rtl/tlp_dword_fifo_pkg.sv
// Shared constants for the TLP receive path: DWORD width and FIFO sizing defaults.
package tlp_dword_fifo_pkg;

   localparam int unsigned TLP_DW_WIDTH  = 32;
   localparam int unsigned FIFO_DEPTH    = 16;
   localparam int unsigned FIFO_AW       = 4;
   localparam int unsigned FIFO_AF_LEVEL = 12;

endpackage

// File: rtl/tlp_dword_fifo_up_down_counter.sv
// Generic up/down counter: counts by one in the direction of 'up' when enabled.
module up_down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   output logic [WIDTH-1:0] count
);

   // Count register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         if (up) count <= count + 1'b1;
         else    count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/tlp_dword_fifo.sv
// Show-ahead DWORD FIFO in front of the TLP detector, valid/ready on both sides.
module tlp_dword_fifo
   import tlp_dword_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = TLP_DW_WIDTH,
   parameter int unsigned DEPTH    = FIFO_DEPTH,
   parameter int unsigned AW       = FIFO_AW,
   parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   input  logic             rd_ready,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             ovf_err
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   // Status decode and handshake qualification, all from the registered count.
   always_comb begin
      full        = (count == FULL_LVL);
      empty       = (count == '0);
      almost_full = (count >= AF_LVL);
      wr_ready    = ~full;
      rd_valid    = ~empty;
      push        = wr_valid & wr_ready & ~reset;
      pop         = rd_valid & rd_ready & ~reset;
      rd_data     = mem[rd_ptr];
   end

   // Occupancy counter: a simultaneous push and pop cancel out.
   up_down_counter #(
      .WIDTH (AW+1)
   ) u_count (
      .clk    (clk),
      .reset  (reset),
      .enable (push ^ pop),
      .up     (push),
      .count  (count)
   );

   // Pointer registers; power-of-two depth gives natural wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Sticky overflow flag: any write attempt while full, word is dropped.
   always_ff @(posedge clk) begin
      if (reset)                ovf_err <= 1'b0;
      else if (wr_valid & full) ovf_err <= 1'b1;
   end

endmodule

// File: tb/tb_tlp_dword_fifo.sv
// Scoreboard bench for tlp_dword_fifo: stimulus queues expected words, monitor checks pops.
module tb_tlp_dword_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_ready = 1'b0;
   logic [4:0]  count;
   logic        full, empty, almost_full, ovf_err;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   logic [31:0] exp_q[$];
   int unsigned mcount = 0;
   logic        movf = 1'b0;

   tlp_dword_fifo #(
      .WIDTH    (32),
      .DEPTH    (16),
      .AW       (4),
      .AF_LEVEL (12)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_ready    (rd_ready),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .ovf_err     (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_status();
      chk("count",       32'(count),       32'(mcount));
      chk("empty",       32'(empty),       32'(mcount == 0));
      chk("full",        32'(full),        32'(mcount == 16));
      chk("almost_full", 32'(almost_full), 32'(mcount >= 12));
      chk("wr_ready",    32'(wr_ready),    32'(mcount != 16));
      chk("rd_valid",    32'(rd_valid),    32'(mcount != 0));
      chk("ovf_err",     32'(ovf_err),     32'(movf));
   endtask

   // One clock of stimulus; the model decides acceptance from its own count.
   task automatic step(input logic wv, input logic [31:0] wd, input logic rr);
      bit mpush, mpop;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      mpush = wv && (mcount != 16);
      mpop  = rr && (mcount != 0);
      if (mpush) exp_q.push_back(wd);
      if (wv && mcount == 16) movf = 1'b1;
      @(posedge clk);
      #1;
      if (mpush && !mpop) mcount++;
      if (mpop && !mpush) mcount--;
      chk_status();
   endtask

   task automatic do_reset(input logic wv, input logic [31:0] wd);
      reset    = 1'b1;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mcount = 0;
      movf   = 1'b0;
      exp_q.delete();
      chk_status();
   endtask

   // Monitor: each accepted pop must match the oldest queued word.
   always @(negedge clk) begin
      if (reset === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL rd_pop: got 0x%0h expected no pop (scoreboard empty)", rd_data);
         end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      #1;
      // 1: reset then idle
      do_reset(1'b0, '0);
      step(1'b0, '0, 1'b0);
      // 2: fill with 1..16, no reads
      for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0);
      // 3: writes while full are dropped and flag overflow
      for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD, 1'b0);
      // 4: drain in order; extra pop while empty is ignored
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      // 5: reach count 5, then concurrent push/pop across pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + 32'(i), 1'b1);
      // 6: count 7, reset (with a push attempt that must be ignored)
      for (int i = 0; i < 2; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
      do_reset(1'b1, 32'hBAD0);
      step(1'b1, 32'hCAFE, 1'b0);
      step(1'b1, 32'hBEEF, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
